writeback_cdb: RTL and testbench
================================

// Module: writeback_cdb
// PURPOSE
//  Completion stage directly downstream of the issue/execute stage. Buffers results from the
//  three functional units (FU0 ALU, FU1 ALU, FU2 LW/SW) in per-unit FIFOs and broadcasts one
//  result per cycle on the common data bus (CDB) to the ROB and reservation stations.
//  Drives per-unit busy bits back to issue (the func_units vector) for backpressure.
// PARAMETERS
//  DEPTH   4   entries per FU result FIFO (power of 2, >=2)
//  DATA_W  32  result value width
//  TAG_W   6   ROB tag width
//  REG_W   5   destination architectural register width
// PORTS
//  clk          in   1          clock, all state updates on posedge
//  rst_n        in   1          synchronous active-low reset
//  fu_valid     in   3          bit i: FU i presents a result this cycle
//  fu_data      in   3*DATA_W   packed results, FU i at [i*DATA_W +: DATA_W] (FU2: load data or store address)
//  fu_tag       in   3*TAG_W    packed ROB tags
//  fu_rd        in   3*REG_W    packed destination registers
//  fu_is_store  in   1          FU2 result is a SW address (no register write)
//  cdb_stall    in   1          ROB cannot accept a broadcast this cycle
//  flush        in   1          discard all buffered results (mispredict/exception)
//  fu_busy      out  3          bit i = 1 when FIFO i is full; feeds issue func_units input
//  cdb_valid    out  1          broadcast valid (registered)
//  cdb_data     out  DATA_W     broadcast value (registered)
//  cdb_tag      out  TAG_W      broadcast ROB tag (registered)
//  cdb_rd       out  REG_W      broadcast destination register (registered)
//  cdb_is_store out  1          broadcast is a store address (registered)
//  cdb_src      out  2          FU index of broadcast (registered)
//  overflow     out  1          sticky: a push was dropped because its FIFO was full
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all FIFO counts/pointers 0, RR pointer 0, every output 0.
//  Push: at posedge, FIFO i stores {data,tag,rd,is_store} iff fu_valid[i] && count_i<DEPTH,
//   with count sampled before the edge; a same-cycle pop does NOT free a slot for that push.
//   fu_valid[i] while full: entry dropped, overflow<=1, held until reset.
//  fu_busy[i] = (count_i==DEPTH), combinational from registered count.
//  Arbitration: round-robin over non-empty FIFOs starting at RR pointer; after granting FU g,
//   RR pointer <= (g+1) mod 3. No grant -> pointer unchanged.
//  Pop/broadcast: if !cdb_stall and any FIFO non-empty, at posedge pop granted head into
//   cdb_* regs, cdb_valid<=1, cdb_src<=g; else cdb_valid<=0 (stall: cdb_* all hold, incl valid).
//  Latency: result pushed at edge E is earliest visible on CDB after edge E+1.
//  FIFO order preserved per FU; pointers wrap modulo DEPTH; simultaneous push+pop on one
//   FIFO: count unchanged (push only if not full pre-edge).
//  fu_is_store ignored for FU0/FU1 (stored as 0).
//  Flush (priority below reset, above push/pop): at posedge all counts/pointers 0,
//   cdb_valid<=0, same-cycle pushes discarded; RR pointer and overflow retained.
//  Reset asserted mid-operation: identical to power-on reset; in-flight entries lost.
// TESTING
//  Reset: hold rst_n=0 2 cycles with fu_valid=3'b111 -> all outputs 0, fu_busy=000, no pushes.
//  Single: FU1 push data=0x5,tag=3,rd=7 -> next cycle cdb_valid=1,data=0x5,tag=3,rd=7,src=1; then valid=0.
//  Fairness: all 3 push same cycle after reset -> CDB src order 0,1,2 on consecutive cycles.
//  Full/overflow: cdb_stall=1, push FU2 x4 (data 0x10..0x13) -> fu_busy=100; 5th push dropped,
//   overflow=1; stall=0 -> 0x10,0x11,0x12,0x13 broadcast in order, fu_busy back to 000.
//  Store: FU2 push is_store=1,data=0x40 -> cdb_is_store=1,data=0x40; FU0 push with is_store=1 -> cdb_is_store=0.
//  Flush: 2 entries in FU0, 1 in FU1, assert flush -> next cycle cdb_valid=0, fu_busy=000,
//   no broadcasts afterwards; overflow unchanged.

Source files
------------

// File: rtl/writeback_cdb.sv
// Writeback / CDB stage: per-FU result FIFOs feeding a round-robin arbiter that
// broadcasts one registered result per cycle to the ROB and reservation stations.
module writeback_cdb #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int REG_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          fu_valid,
  input  logic [3*DATA_W-1:0] fu_data,
  input  logic [3*TAG_W-1:0]  fu_tag,
  input  logic [3*REG_W-1:0]  fu_rd,
  input  logic                fu_is_store,
  input  logic                cdb_stall,
  input  logic                flush,
  output logic [2:0]          fu_busy,
  output logic                cdb_valid,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [REG_W-1:0]    cdb_rd,
  output logic                cdb_is_store,
  output logic [1:0]          cdb_src,
  output logic                overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_data [3][DEPTH];
  logic [TAG_W-1:0]  mem_tag  [3][DEPTH];
  logic [REG_W-1:0]  mem_rd   [3][DEPTH];
  logic              mem_st   [3][DEPTH];

  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [AW:0]   count  [3];
  logic [1:0]    rr_ptr;

  logic [1:0] grant;
  logic       grant_valid;
  logic       pop_en;
  logic [2:0] push_en;
  logic [2:0] pop_sel;
  logic [2:0] cand;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room.
  always_comb begin
    fu_busy = '0;
    push_en = '0;
    pop_sel = '0;
    for (int i = 0; i < 3; i++) begin
      fu_busy[i] = (count[i] == FULL_CNT);
      push_en[i] = fu_valid[i] && (count[i] != FULL_CNT);
      pop_sel[i] = pop_en && (grant == 2'(i));
    end
  end

  // Round-robin search over non-empty FIFOs, starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant       = rr_ptr;
    cand        = '0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_valid && (count[cand[1:0]] != '0)) begin
        grant_valid = 1'b1;
        grant       = cand[1:0];
      end
    end
    pop_en = grant_valid && !cdb_stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr       <= '0;
      cdb_valid    <= 1'b0;
      cdb_data     <= '0;
      cdb_tag      <= '0;
      cdb_rd       <= '0;
      cdb_is_store <= 1'b0;
      cdb_src      <= '0;
      overflow     <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push_en[i]) begin
          mem_data[i][wr_ptr[i]] <= fu_data[i*DATA_W +: DATA_W];
          mem_tag[i][wr_ptr[i]]  <= fu_tag[i*TAG_W +: TAG_W];
          mem_rd[i][wr_ptr[i]]   <= fu_rd[i*REG_W +: REG_W];
          mem_st[i][wr_ptr[i]]   <= (i == 2) ? fu_is_store : 1'b0;
          wr_ptr[i]              <= wr_ptr[i] + 1'b1;
        end
        if (pop_sel[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push_en[i], pop_sel[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
        if (fu_valid[i] && fu_busy[i]) overflow <= 1'b1;
      end
      // A stall freezes every CDB register, including valid, so the ROB sees a stable bus.
      if (pop_en) begin
        cdb_valid    <= 1'b1;
        cdb_data     <= mem_data[grant][rd_ptr[grant]];
        cdb_tag      <= mem_tag[grant][rd_ptr[grant]];
        cdb_rd       <= mem_rd[grant][rd_ptr[grant]];
        cdb_is_store <= mem_st[grant][rd_ptr[grant]];
        cdb_src      <= grant;
        rr_ptr       <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
      end else if (!cdb_stall) begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_cdb.sv
// Self-checking bench for writeback_cdb: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the completion stage.
module tb_writeback_cdb;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int REG_W  = 5;

  logic                clk;
  logic                rst_n;
  logic [2:0]          fu_valid;
  logic [3*DATA_W-1:0] fu_data;
  logic [3*TAG_W-1:0]  fu_tag;
  logic [3*REG_W-1:0]  fu_rd;
  logic                fu_is_store;
  logic                cdb_stall;
  logic                flush;
  logic [2:0]          fu_busy;
  logic                cdb_valid;
  logic [DATA_W-1:0]   cdb_data;
  logic [TAG_W-1:0]    cdb_tag;
  logic [REG_W-1:0]    cdb_rd;
  logic                cdb_is_store;
  logic [1:0]          cdb_src;
  logic                overflow;

  writeback_cdb #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .fu_valid(fu_valid), .fu_data(fu_data), .fu_tag(fu_tag),
    .fu_rd(fu_rd), .fu_is_store(fu_is_store), .cdb_stall(cdb_stall), .flush(flush),
    .fu_busy(fu_busy), .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .cdb_rd(cdb_rd), .cdb_is_store(cdb_is_store), .cdb_src(cdb_src), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    logic [REG_W-1:0]  r;
    logic              s;
  } ent_t;

  ent_t q [3][$];
  int   rr;
  logic              e_valid, e_store, e_ovf;
  logic [DATA_W-1:0] e_data;
  logic [TAG_W-1:0]  e_tag;
  logic [REG_W-1:0]  e_rd;
  logic [1:0]        e_src;

  int vectors;
  int miscompares;

  // Reference: broadcast picks the first non-empty queue from rr, pushes judged on pre-edge sizes.
  task automatic modelStep();
    int   sz [3];
    int   g;
    ent_t e;
    for (int i = 0; i < 3; i++) sz[i] = q[i].size();
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      rr = 0; e_valid = 0; e_data = 0; e_tag = 0; e_rd = 0; e_store = 0; e_src = 0; e_ovf = 0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      e_valid = 0;
    end else begin
      g = -1;
      if (!cdb_stall)
        for (int k = 0; k < 3; k++)
          if (g < 0 && sz[(rr + k) % 3] > 0) g = (rr + k) % 3;
      if (g >= 0) begin
        e = q[g].pop_front();
        e_valid = 1; e_data = e.d; e_tag = e.t; e_rd = e.r; e_store = e.s; e_src = 2'(g);
        rr = (g + 1) % 3;
      end else if (!cdb_stall) begin
        e_valid = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (fu_valid[i]) begin
          if (sz[i] < DEPTH) begin
            e.d = fu_data[i*DATA_W +: DATA_W];
            e.t = fu_tag[i*TAG_W +: TAG_W];
            e.r = fu_rd[i*REG_W +: REG_W];
            e.s = (i == 2) ? fu_is_store : 1'b0;
            q[i].push_back(e);
          end else begin
            e_ovf = 1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic compareAll();
    logic [2:0] busy;
    for (int i = 0; i < 3; i++) busy[i] = (q[i].size() == DEPTH);
    checkOutput("fu_busy", 64'(fu_busy), 64'(busy));
    checkOutput("overflow", 64'(overflow), 64'(e_ovf));
    checkOutput("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    if (e_valid) begin
      checkOutput("cdb_data", 64'(cdb_data), 64'(e_data));
      checkOutput("cdb_tag", 64'(cdb_tag), 64'(e_tag));
      checkOutput("cdb_rd", 64'(cdb_rd), 64'(e_rd));
      checkOutput("cdb_is_store", 64'(cdb_is_store), 64'(e_store));
      checkOutput("cdb_src", 64'(cdb_src), 64'(e_src));
    end
  endtask

  // One clock: inputs are already set, so advance the model with them and check #1 later.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic clearInputs();
    fu_valid = '0; fu_data = '0; fu_tag = '0; fu_rd = '0;
    fu_is_store = 1'b0; cdb_stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
  endtask

  task automatic setFu(input int i, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                       input logic [REG_W-1:0] r);
    fu_valid[i] = 1'b1;
    fu_data[i*DATA_W +: DATA_W] = d;
    fu_tag[i*TAG_W +: TAG_W] = t;
    fu_rd[i*REG_W +: REG_W] = r;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    fu_valid = 3'b111;
    applyStimulus();
    applyStimulus();
    clearInputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rr = 0;
    e_valid = 0; e_data = 0; e_tag = 0; e_rd = 0; e_store = 0; e_src = 0; e_ovf = 0;
    clearInputs();

    doReset();
    checkOutput("reset_valid", 64'(cdb_valid), 64'd0);
    checkOutput("reset_busy", 64'(fu_busy), 64'd0);
    checkOutput("reset_data", 64'(cdb_data), 64'd0);
    applyStimulus();
    checkOutput("reset_no_push", 64'(cdb_valid), 64'd0);

    // Single FU1 result appears one cycle after its push edge.
    setFu(1, 32'h5, 6'd3, 5'd7);
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("single_valid", 64'(cdb_valid), 64'd1);
    checkOutput("single_data", 64'(cdb_data), 64'h5);
    checkOutput("single_tag", 64'(cdb_tag), 64'd3);
    checkOutput("single_rd", 64'(cdb_rd), 64'd7);
    checkOutput("single_src", 64'(cdb_src), 64'd1);
    applyStimulus();
    checkOutput("single_after", 64'(cdb_valid), 64'd0);

    // Fairness from a fresh reset: sources 0,1,2 in order.
    doReset();
    setFu(0, 32'hA0, 6'd1, 5'd1);
    setFu(1, 32'hA1, 6'd2, 5'd2);
    setFu(2, 32'hA2, 6'd3, 5'd3);
    applyStimulus();
    clearInputs();
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("fair_src", 64'(cdb_src), 64'(k));
    end

    // FU2 fills under stall, fifth push overflows, then drains in order.
    clearInputs();
    applyStimulus();
    cdb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      setFu(2, 32'h10 + 32'(k), 6'(k), 5'(k));
      applyStimulus();
    end
    checkOutput("full_busy", 64'(fu_busy), 64'b100);
    setFu(2, 32'h99, 6'd9, 5'd9);
    applyStimulus();
    fu_valid = '0;
    checkOutput("ovf_set", 64'(overflow), 64'd1);
    cdb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("drain_data", 64'(cdb_data), 64'h10 + 64'(k));
    end
    checkOutput("drain_busy", 64'(fu_busy), 64'd0);

    // Store flag honoured only for FU2.
    doReset();
    fu_is_store = 1'b1;
    setFu(2, 32'h40, 6'd4, 5'd0);
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("store_flag", 64'(cdb_is_store), 64'd1);
    checkOutput("store_data", 64'(cdb_data), 64'h40);
    fu_is_store = 1'b1;
    setFu(0, 32'h41, 6'd5, 5'd2);
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("alu_no_store", 64'(cdb_is_store), 64'd0);

    // Flush drops buffered entries but keeps the sticky overflow.
    cdb_stall = 1'b1;
    setFu(0, 32'h50, 6'd1, 5'd1);
    setFu(1, 32'h60, 6'd2, 5'd2);
    applyStimulus();
    fu_valid = 3'b001;
    fu_data[31:0] = 32'h51;
    applyStimulus();
    clearInputs();
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    checkOutput("flush_valid", 64'(cdb_valid), 64'd0);
    checkOutput("flush_busy", 64'(fu_busy), 64'd0);
    for (int k = 0; k < 3; k++) applyStimulus();

    // Random traffic with stalls, flushes and rare resets.
    for (int n = 0; n < 3000; n++) begin
      clearInputs();
      for (int i = 0; i < 3; i++)
        if ($urandom_range(99) < 55) setFu(i, $urandom(), 6'($urandom()), 5'($urandom()));
      fu_is_store = 1'($urandom());
      cdb_stall = ($urandom_range(99) < 30);
      flush = ($urandom_range(99) < 2);
      rst_n = !($urandom_range(999) < 4);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
